// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA job sequencer.
package rsa_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StKeygen,
        StLoad,
        StRun,
        StResp
    } seq_state_e;

    // Cycles spent in LOAD: control's register stage plus mod_exp's reset.
    localparam int unsigned LOAD_CYCLES = 2;

    // Width of the shared cycle counter, wide enough for the longer of the two waits.
    function automatic int unsigned cnt_width(input int unsigned keygen_cycles,
                                              input int unsigned timeout);
        int unsigned longest;
        longest = (keygen_cycles > timeout) ? keygen_cycles : timeout;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rsa_cycle_timer.sv
// Loadable, saturating down-counter with a done flag; shared by KEYGEN, LOAD and RUN.
module rsa_cycle_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load on request, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/rsa_job_sequencer.sv
// Sequences key generation, message load, mod-exp run and result capture on `control`.
module rsa_job_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned KEYGEN_CYCLES = 256,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [WIDTH-1:0]   req_p_i,
    input  logic [WIDTH-1:0]   req_q_i,
    input  logic               req_encrypt_i,
    input  logic [WIDTH-1:0]   req_msg_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [2*WIDTH-1:0] rsp_msg_o,
    output logic               rsp_error_o,
    output logic               busy_o,
    output logic [WIDTH-1:0]   ctl_p_o,
    output logic [WIDTH-1:0]   ctl_q_o,
    output logic               ctl_encrypt_decrypt_o,
    output logic [WIDTH-1:0]   ctl_msg_in_o,
    output logic               ctl_key_reset_o,
    output logic               ctl_exp_reset_o,
    input  logic [2*WIDTH-1:0] ctl_msg_out_i,
    input  logic               ctl_mod_exp_finish_i
);

    import rsa_pkg::*;

    localparam int unsigned CNT_W = cnt_width(KEYGEN_CYCLES, TIMEOUT);
    // KEYGEN holds one pulse cycle plus KEYGEN_CYCLES of wait, hence no -1.
    localparam logic [CNT_W-1:0] KeygenLoad = CNT_W'(KEYGEN_CYCLES);
    localparam logic [CNT_W-1:0] LoadLoad   = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RunLoad    = CNT_W'(TIMEOUT - 1);

    seq_state_e state_q, state_d;

    logic               key_valid_q, key_valid_d;
    logic [WIDTH-1:0]   cache_p_q, cache_p_d;
    logic [WIDTH-1:0]   cache_q_q, cache_q_d;
    logic [WIDTH-1:0]   ctl_p_q, ctl_p_d;
    logic [WIDTH-1:0]   ctl_q_q, ctl_q_d;
    logic               ctl_enc_q, ctl_enc_d;
    logic [WIDTH-1:0]   ctl_msg_q, ctl_msg_d;
    logic               key_rst_q, key_rst_d;
    logic               exp_rst_q, exp_rst_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] rsp_msg_q, rsp_msg_d;
    logic               rsp_err_q, rsp_err_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic [CNT_W-1:0]   tmr_count;
    logic               tmr_done;
    logic               run_first;

    rsa_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_o    (tmr_count),
        .done_o     (tmr_done)
    );

    // The timer still holds its load value only in the first RUN cycle.
    assign run_first = (tmr_count == RunLoad);

    // Next-state, datapath latching and registered-output decode.
    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        cache_p_d   = cache_p_q;
        cache_q_d   = cache_q_q;
        ctl_p_d     = ctl_p_q;
        ctl_q_d     = ctl_q_q;
        ctl_enc_d   = ctl_enc_q;
        ctl_msg_d   = ctl_msg_q;
        key_rst_d   = key_rst_q;
        rsp_msg_d   = rsp_msg_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_q) begin
                    ctl_p_d   = req_p_i;
                    ctl_q_d   = req_q_i;
                    ctl_enc_d = req_encrypt_i;
                    ctl_msg_d = req_msg_i;
                    if (key_valid_q && (req_p_i == cache_p_q) && (req_q_i == cache_q_q)) begin
                        state_d = StLoad;
                    end else begin
                        state_d     = StKeygen;
                        key_rst_d   = 1'b1;
                        key_valid_d = 1'b0;
                    end
                end
            end
            StKeygen: begin
                key_rst_d = 1'b0;
                if (tmr_done) begin
                    key_valid_d = 1'b1;
                    cache_p_d   = ctl_p_q;
                    cache_q_d   = ctl_q_q;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                if (tmr_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A finish seen in the first RUN cycle may be left over from the last job.
                if (ctl_mod_exp_finish_i && !run_first) begin
                    rsp_msg_d = ctl_msg_out_i;
                    rsp_err_d = 1'b0;
                    state_d   = StResp;
                end else if (tmr_done) begin
                    rsp_msg_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every state entry reloads the shared timer.
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        unique case (state_d)
            StKeygen: tmr_load_val = KeygenLoad;
            StLoad:   tmr_load_val = LoadLoad;
            StRun:    tmr_load_val = RunLoad;
            default:  tmr_load_val = '0;
        endcase

        req_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        rsp_valid_d = (state_d == StResp);
        exp_rst_d   = (state_d != StRun);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            key_valid_q <= 1'b0;
            cache_p_q   <= '0;
            cache_q_q   <= '0;
            ctl_p_q     <= '0;
            ctl_q_q     <= '0;
            ctl_enc_q   <= 1'b0;
            ctl_msg_q   <= '0;
            key_rst_q   <= 1'b1;
            exp_rst_q   <= 1'b1;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_msg_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            cache_p_q   <= cache_p_d;
            cache_q_q   <= cache_q_d;
            ctl_p_q     <= ctl_p_d;
            ctl_q_q     <= ctl_q_d;
            ctl_enc_q   <= ctl_enc_d;
            ctl_msg_q   <= ctl_msg_d;
            key_rst_q   <= key_rst_d;
            exp_rst_q   <= exp_rst_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            rsp_msg_q   <= rsp_msg_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o           = req_ready_q;
    assign rsp_valid_o           = rsp_valid_q;
    assign rsp_msg_o             = rsp_msg_q;
    assign rsp_error_o           = rsp_err_q;
    assign busy_o                = busy_q;
    assign ctl_p_o               = ctl_p_q;
    assign ctl_q_o               = ctl_q_q;
    assign ctl_encrypt_decrypt_o = ctl_enc_q;
    assign ctl_msg_in_o          = ctl_msg_q;
    assign ctl_key_reset_o       = key_rst_q;
    assign ctl_exp_reset_o       = exp_rst_q;

endmodule

// File: doc/rsa_job_sequencer.md
Name: rsa_job_sequencer

Overview:
- Drives the RSA `control` datapath: key-generation start, message load, mod-exp run, result capture.
- Accepts encrypt/decrypt jobs on a valid/ready request channel. Returns results on a valid/ready response channel.
- Caches the last (p, q) pair, so key generation reruns only when the primes change.
- Instantiated beside `control` in the SoC top; its ctl_* ports connect 1:1 to `control`'s ports.

Parameters:
- WIDTH, 32: prime and message width; results are 2*WIDTH.
- KEYGEN_CYCLES, 256: fixed wait after the key-reset pulse. `control` exposes no inverter finish signal, so this wait stands in for it.
- TIMEOUT, 4096: maximum RUN cycles before the job is aborted with an error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_p  in  WIDTH  prime p
- req_q  in  WIDTH  prime q
- req_encrypt  in  1  1 = encrypt (key e), 0 = decrypt (key d)
- req_msg  in  WIDTH  message
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts the result
- rsp_msg  out  2*WIDTH  result
- rsp_error  out  1  job timed out
- busy  out  1  high in any state other than IDLE
- ctl_p, ctl_q  out  WIDTH  to control.p / control.q
- ctl_encrypt_decrypt  out  1  to control.encrypt_decrypt
- ctl_msg_in  out  WIDTH  to control.msg_in
- ctl_key_reset  out  1  to control.reset (inverter)
- ctl_exp_reset  out  1  to control.reset1 (mod_exp)
- ctl_msg_out  in  2*WIDTH  from control.msg_out
- ctl_mod_exp_finish  in  1  from control.mod_exp_finish

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_msg=0, rsp_error=0, busy=0.
  - ctl_p/q/msg_in=0, ctl_encrypt_decrypt=0, ctl_key_reset=1, ctl_exp_reset=1.
  - key_valid=0, state=IDLE.
  - req_ready rises in the first cycle after reset deasserts.
- IDLE:
  - req_ready=1 and ctl_exp_reset=1.
  - Handshake on req_valid && req_ready at cycle T. On it, latch p, q, encrypt and msg into the ctl_* outputs.
  - Go to LOAD if key_valid and p,q equal the cached pair; otherwise go to KEYGEN.
  - Request inputs are ignored outside IDLE.
- KEYGEN:
  - Cycle T+1: ctl_key_reset=1 (single-cycle pulse); clear key_valid.
  - Then ctl_key_reset=0 for KEYGEN_CYCLES cycles.
  - On exit: set key_valid, cache p and q, go to LOAD.
  - ctl_key_reset stays 0 afterwards until reset.
- LOAD:
  - Exactly 2 cycles with ctl_exp_reset=1 and ctl_* data stable.
  - Covers `control`'s one-cycle exp/mod/msg register stage plus mod_exp's reset.
- RUN:
  - ctl_exp_reset=0; the cycle counter starts at 0.
  - ctl_mod_exp_finish is ignored in the first RUN cycle, which blanks a stale finish from the previous job.
  - From the second RUN cycle, finish=1 captures ctl_msg_out into rsp_msg, sets rsp_error=0, and goes to RESP.
  - After TIMEOUT RUN cycles with no finish: rsp_msg=0, rsp_error=1, go to RESP.
- RESP:
  - rsp_valid=1, with rsp_msg and rsp_error held stable until rsp_ready.
  - On the handshake cycle, go to IDLE with ctl_exp_reset=1 and rsp_valid=0 in the next cycle.
  - If rsp_ready is already high on entry, rsp_valid lasts exactly 1 cycle.
- Latency, cache hit: LOAD T+1..T+2, RUN from T+3. Earliest rsp_valid is T+5 (finish sampled at T+4).
- Latency, cache miss: add KEYGEN_CYCLES+1.
- Reset mid-job: all outputs return to reset values in the next cycle. key_valid is cleared, so the next job always regenerates keys.
- Validation: p and q are not checked for primality or zero; they are passed through unchanged.
- Counter: one shared counter of width clog2(max(KEYGEN_CYCLES, TIMEOUT)+1); saturating; cleared on every state entry.

Decomposition:
- Shared package (rsa_pkg):
  - state encoding IDLE/KEYGEN/LOAD/RUN/RESP
  - constant LOAD_CYCLES=2
  - counter-width function
- One sub-module, rsa_cycle_timer: loadable down-counter with a done flag, reused by KEYGEN, LOAD and RUN.

Test Plan (the bench uses a `control` stub: finish rises 10 cycles after reset1 falls, msg_out=2790):
- First job (p=61, q=53, encrypt=1, msg=65) -> ctl_key_reset high exactly at T+1; ctl_exp_reset falls at T+4+KEYGEN_CYCLES; rsp_msg=2790, rsp_error=0.
- Repeat with the same p,q, and the stub holding finish=1 at RUN entry -> no key pulse; ctl_exp_reset falls at T+3; finish in the first RUN cycle is ignored; the result comes from the real finish.
- Change q to 59 -> KEYGEN is re-entered, with the key pulse at T+1.
- Stub never finishes -> rsp_valid after exactly TIMEOUT RUN cycles, with rsp_error=1 and rsp_msg=0.
- rsp_ready held low 5 cycles with req_valid=1 -> rsp_valid/rsp_msg stable and req_ready=0; the request is taken only after the response handshake.
- reset pulsed mid-RUN -> next cycle ctl_exp_reset=1, ctl_key_reset=1, rsp_valid=0; a following job with the same p,q performs KEYGEN.
